i2c_slave_controller: RTL and testbench
=======================================

Name: i2c_slave_controller

Overview:
I2C target (slave) endpoint, the responder to i2c_master_controller on the same two-wire bus. Oversamples SCL/SDA with the 50 MHz system clock and detects START/STOP. Matches a 7-bit address, ACKs, and moves bytes between the bus and the RX/TX FIFOs. Standard/fast mode only; no clock stretching and no 10-bit addressing.

Parameters:
HOLD_CYCLES, 15, clk cycles from a detected SCL falling edge to an SDA change (300 ns data hold at 50 MHz); legal range 1..31.

Ports:
reset  input  1  asynchronous, active-low reset
clk  input  1  system clock, 50 MHz
own_address  input  7  device address; sampled on the 8th address bit; software holds it stable while busy=1
read  output  1  one-clk read pulse to the TX FIFO
data_in  input  8  TX FIFO data, first-word-fall-through (valid in the same clk as read)
empty_tx  input  1  TX FIFO empty
write  output  1  one-clk write pulse to the RX FIFO
data_out  output  8  received byte; valid while write=1, holds its value otherwise
full_rx  input  1  RX FIFO full
busy  output  1  bus busy: set at START, cleared at STOP
scl  input  1  bus serial clock (never driven)
sda  inout  1  open-drain data: driven 0 or released (z), never driven 1

Behaviour:
Reset (reset=0, any time, mid-byte included):
- state=IDLE; read=0, write=0, data_out=8'h00, busy=0; sda released.
- Synchronizers reset to 1.

Input conditioning:
- scl and sda each pass through a 2-FF synchronizer plus one history FF.
- Edges are computed from the synced and history bits; latency bus to internal edge is 3 clk.
- START: sda falls while synced scl=1. STOP: sda rises while synced scl=1.
- Data is sampled on the SCL rising edge. SDA is changed only HOLD_CYCLES clk after an SCL falling edge, using a 5-bit hold counter.

START/STOP priority:
- START or STOP is detected in any state and overrides everything else.
- START (including repeated START): release sda, clear the bit counter, go to ADDR, busy=1.
- STOP: release sda, go to IDLE, busy=0.

States:
- IDLE: wait for START.
- ADDR: shift 8 bits MSB-first. At the 8th rise:
  - [7:1]==own_address: go to ADDR_ACK.
  - otherwise: go to WAIT_STOP and never drive sda.
- ADDR_ACK:
  - Drive sda=0 from fall#8+HOLD until fall#9+HOLD.
  - R/W=0: go to RX_DATA at that release point.
  - R/W=1: go to TX_LOAD at fall#8+HOLD, so the ACK drive and the TX load happen together.
- RX_DATA: shift 8 bits. At the 8th rise:
  - full_rx=0: write=1 for exactly 1 clk with data_out=byte; ACK on the 9th bit.
  - full_rx=1: no write; NACK (sda released on the 9th bit).
  - Either way, return to RX_DATA for the next byte; the master decides whether to continue.
- TX_LOAD (1 clk): if empty_tx=0, read=1 and shift_reg<=data_in; if empty_tx=1, shift_reg<=8'hFF and no read pulse.
- TX_DATA:
  - Drive bit7 at fall#9+HOLD of the previous ACK slot; shift on each subsequent fall+HOLD.
  - A 1 bit means release, a 0 bit means drive low.
  - After the 8th bit's falling edge+HOLD, release sda and go to TX_ACK.
- TX_ACK: sample sda at the 9th rise.
  - 0 (master ACK): go to TX_LOAD, so the next byte is fetched before fall#9+HOLD.
  - 1 (master NACK): go to WAIT_STOP with sda released.
- WAIT_STOP: ignore SCL; leave only on START or STOP.

Counters and arbitration:
- Bit counter is 4 bits (0..8) and wraps to 0 after the ACK slot.
- If the sda value read back differs from the bit being transmitted, that is a bus error: release and go to WAIT_STOP.

Simultaneous events:
- A STOP on the same clk as an internal SCL edge: STOP wins.
- write and read never assert in the same clk.

Test Plan:
- Master writes addr 0x50/W, data 0xA5, 0x3C, STOP; own_address=7'h50, full_rx=0 -> sda low in 3 ACK slots; write pulses with data_out=0xA5 then 0x3C; busy 1→0 at STOP.
- Master addresses 0x51/W with own_address=7'h50 -> sda never driven; no write/read; state WAIT_STOP until STOP; busy=1 until STOP.
- Read from 0x50, TX FIFO holds 0x96, 0x0F; master ACKs the first byte and NACKs the second -> read pulses twice; bus bits 1001_0110 then 0000_1111; sda released after the second byte; no third read.
- Read with empty_tx=1 -> address ACKed, 0xFF on the bus, read never pulses.
- Write 0x11 with full_rx=1 -> address ACKed, data byte NACKed (sda high at 9th rise), write never pulses.
- Repeated START after a written byte 0x22, then 0x50/R -> write for 0x22, new address phase, TX transfer correct. Also assert reset=0 mid-byte -> sda released within the same clk, all outputs at reset values.

Source files
------------

// File: rtl/i2c_slave_controller.sv
// I2C target endpoint: 7-bit address match, ACK/NACK,
// byte moves between the bus and RX/TX FIFOs.
module i2c_slave_controller #(
  parameter int HOLD_CYCLES = 15
) (
  input  logic       reset,
  input  logic       clk,
  input  logic [6:0] own_address,
  output logic       read,
  input  logic [7:0] data_in,
  input  logic       empty_tx,
  output logic       write,
  output logic [7:0] data_out,
  input  logic       full_rx,
  output logic       busy,
  input  logic       scl,
  inout  wire        sda
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] RX_DATA   = 3'd3;
  localparam logic [2:0] TX_LOAD   = 3'd4;
  localparam logic [2:0] TX_DATA   = 3'd5;
  localparam logic [2:0] TX_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  localparam logic [4:0] HOLD = 5'(HOLD_CYCLES);

  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [4:0] hold_cnt;
  logic       sda_oe;
  logic       rw;
  logic       ack_ok;

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  logic scl_rise, scl_fall;
  logic sda_rise, sda_fall;
  logic start_det, stop_det;
  logic hold_done;

  // Open-drain: only ever pull low or let go.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign sda_rise  = sda_s2 & ~sda_h;
  assign sda_fall  = ~sda_s2 & sda_h;
  assign start_det = sda_fall & scl_s2;
  assign stop_det  = sda_rise & scl_s2;
  assign hold_done = (hold_cnt == 5'd1);

  // Two-stage synchronizers plus a history stage for edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_h} <= {scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {sda, sda_s1, sda_s2};
    end
  end

  // Data-hold timer: one-clk hold_done pulse after each SCL fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= 5'd0;
    end else if (scl_fall) begin
      hold_cnt <= HOLD;
    end else if (hold_cnt != 5'd0) begin
      hold_cnt <= hold_cnt - 5'd1;
    end
  end

  // Protocol FSM; START/STOP take priority over everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      sda_oe   <= 1'b0;
      rw       <= 1'b0;
      ack_ok   <= 1'b0;
      read     <= 1'b0;
      write    <= 1'b0;
      data_out <= 8'h00;
      busy     <= 1'b0;
    end else begin
      read  <= 1'b0;
      write <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        if (scl_rise && state != IDLE
            && state != WAIT_STOP) begin
          if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        unique case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_s2};
              if (bit_cnt == 4'd7) begin
                rw <= sda_s2;
                if (shreg[6:0] == own_address) begin
                  state <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (hold_done) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b1;
                if (rw) begin
                  state <= TX_LOAD;
                end
              end else if (bit_cnt == 4'd0) begin
                sda_oe <= 1'b0;
                state  <= RX_DATA;
              end
            end
          end
          RX_DATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg <= {shreg[6:0], sda_s2};
              if (bit_cnt == 4'd7) begin
                ack_ok <= ~full_rx;
                if (!full_rx) begin
                  write    <= 1'b1;
                  data_out <= {shreg[6:0], sda_s2};
                end
              end
            end
            if (hold_done) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= ack_ok;
              end else if (bit_cnt == 4'd0) begin
                sda_oe <= 1'b0;
              end
            end
          end
          TX_LOAD: begin
            if (!empty_tx) begin
              read  <= 1'b1;
              shreg <= data_in;
            end else begin
              shreg <= 8'hFF;
            end
            state <= TX_DATA;
          end
          TX_DATA: begin
            if (scl_rise && bit_cnt < 4'd8
                && sda_s2 == sda_oe) begin
              sda_oe <= 1'b0;
              state  <= WAIT_STOP;
            end else if (hold_done) begin
              if (bit_cnt == 4'd0) begin
                sda_oe <= ~shreg[7];
              end else if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= TX_ACK;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                state <= WAIT_STOP;
              end else begin
                state <= TX_LOAD;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Directed bench: a bit-banged I2C master drives the target
// and checks ACKs, FIFO pulses and bus data.
module tb_i2c_slave_controller;

  localparam int Q = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] own_address = 7'h50;
  logic       read;
  logic [7:0] data_in;
  logic       empty_tx;
  logic       write;
  logic [7:0] data_out;
  logic       full_rx = 1'b0;
  logic       busy;
  logic       scl = 1'b1;
  logic       m_drv = 1'b0;
  wire        sda;

  logic [7:0] tx_mem [0:7];
  int         tx_lim = 0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         both_cnt = 0;
  int         slow_cnt = 0;
  logic [7:0] wr_log [0:15];

  int n_cmp = 0;
  int n_bad = 0;

  assign sda = m_drv ? 1'b0 : 1'bz;
  pullup (sda);

  assign data_in  = tx_mem[rd_cnt[2:0]];
  assign empty_tx = (rd_cnt >= tx_lim);

  always #10 clk = ~clk;

  i2c_slave_controller #(.HOLD_CYCLES(15)) dut (
    .reset(reset),
    .clk(clk),
    .own_address(own_address),
    .read(read),
    .data_in(data_in),
    .empty_tx(empty_tx),
    .write(write),
    .data_out(data_out),
    .full_rx(full_rx),
    .busy(busy),
    .scl(scl),
    .sda(sda)
  );

  // FIFO-side monitor: logs writes, pops TX on read pulses.
  always @(negedge clk) begin
    if (write) begin
      wr_log[wr_cnt[3:0]] <= data_out;
      wr_cnt <= wr_cnt + 1;
    end
    if (read) rd_cnt <= rd_cnt + 1;
    if (read && write) both_cnt <= both_cnt + 1;
    if (!m_drv && sda === 1'b0) slow_cnt <= slow_cnt + 1;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    wclk(Q);
    m_drv = ~b;
    wclk(Q);
    scl = 1'b1;
    wclk(Q);
    s = sda;
    wclk(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    wclk(Q);
    m_drv = 1'b0;
    wclk(Q);
    scl = 1'b1;
    wclk(Q);
    m_drv = 1'b1;
    wclk(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(Q);
    m_drv = 1'b1;
    wclk(Q);
    scl = 1'b1;
    wclk(Q);
    m_drv = 1'b0;
    wclk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d,
                            output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic ackbit,
                           output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
    bit_xfer(ackbit, s);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) tx_mem[i] = 8'h00;
    reset = 1'b0;
    wclk(3);
    n_cmp++; if (read !== 1'b0) begin n_bad++;
      $display("FAIL rst_read got %b want 0", read); end
    n_cmp++; if (write !== 1'b0) begin n_bad++;
      $display("FAIL rst_write got %b want 0", write); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++;
      $display("FAIL rst_data got %h want 00", data_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (sda !== 1'b1) begin n_bad++;
      $display("FAIL rst_sda got %b want 1", sda); end
    reset = 1'b1;
    wclk(5);
  endtask

  task automatic test_write();
    int w0;
    logic a;
    logic [3:0] ix;
    w0 = wr_cnt;
    ix = w0[3:0];
    i2c_start();
    write_byte(8'hA0, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++;
      $display("FAIL wr_addr_ack got %b want 0", a); end
    write_byte(8'hA5, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++;
      $display("FAIL wr_d0_ack got %b want 0", a); end
    write_byte(8'h3C, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++;
      $display("FAIL wr_d1_ack got %b want 0", a); end
    n_cmp++; if (wr_cnt - w0 !== 2) begin n_bad++;
      $display("FAIL wr_count got %0d want 2", wr_cnt - w0); end
    n_cmp++; if (wr_log[ix] !== 8'hA5) begin n_bad++;
      $display("FAIL wr_d0 got %h want a5", wr_log[ix]); end
    n_cmp++; if (wr_log[ix + 4'd1] !== 8'h3C) begin n_bad++;
      $display("FAIL wr_d1 got %h want 3c", wr_log[ix + 4'd1]); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL wr_busy got %b want 1", busy); end
    i2c_stop();
    wclk(5);
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL wr_idle got %b want 0", busy); end
  endtask

  task automatic test_addr_mismatch();
    int w0, r0, s0;
    logic a;
    w0 = wr_cnt; r0 = rd_cnt; s0 = slow_cnt;
    i2c_start();
    write_byte(8'hA2, a);
    n_cmp++; if (a !== 1'b1) begin n_bad++;
      $display("FAIL nm_addr_ack got %b want 1", a); end
    write_byte(8'h00, a);
    n_cmp++; if (a !== 1'b1) begin n_bad++;
      $display("FAIL nm_data_ack got %b want 1", a); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL nm_busy got %b want 1", busy); end
    n_cmp++; if (slow_cnt - s0 !== 0) begin n_bad++;
      $display("FAIL nm_sda_drv got %0d want 0", slow_cnt - s0); end
    n_cmp++; if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin
      n_bad++;
      $display("FAIL nm_fifo got wr %0d rd %0d want 0 0",
               wr_cnt - w0, rd_cnt - r0); end
    i2c_stop();
    wclk(5);
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL nm_idle got %b want 0", busy); end
  endtask

  task automatic test_read();
    int r0;
    logic a;
    logic [7:0] d;
    r0 = rd_cnt;
    tx_mem[r0[2:0]] = 8'h96;
    tx_mem[3'(r0 + 1)] = 8'h0F;
    tx_lim = r0 + 2;
    i2c_start();
    write_byte(8'hA1, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++;
      $display("FAIL rd_addr_ack got %b want 0", a); end
    read_byte(1'b0, d);
    n_cmp++; if (d !== 8'h96) begin n_bad++;
      $display("FAIL rd_b0 got %h want 96", d); end
    read_byte(1'b1, d);
    n_cmp++; if (d !== 8'h0F) begin n_bad++;
      $display("FAIL rd_b1 got %h want 0f", d); end
    wclk(Q);
    n_cmp++; if (sda !== 1'b1) begin n_bad++;
      $display("FAIL rd_release got %b want 1", sda); end
    i2c_stop();
    wclk(5);
    n_cmp++; if (rd_cnt - r0 !== 2) begin n_bad++;
      $display("FAIL rd_count got %0d want 2", rd_cnt - r0); end
  endtask

  task automatic test_empty();
    int r0;
    logic a;
    logic [7:0] d;
    r0 = rd_cnt;
    tx_lim = r0;
    i2c_start();
    write_byte(8'hA1, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++;
      $display("FAIL em_addr_ack got %b want 0", a); end
    read_byte(1'b1, d);
    n_cmp++; if (d !== 8'hFF) begin n_bad++;
      $display("FAIL em_byte got %h want ff", d); end
    i2c_stop();
    wclk(5);
    n_cmp++; if (rd_cnt - r0 !== 0) begin n_bad++;
      $display("FAIL em_reads got %0d want 0", rd_cnt - r0); end
  endtask

  task automatic test_full();
    int w0;
    logic a;
    w0 = wr_cnt;
    full_rx = 1'b1;
    i2c_start();
    write_byte(8'hA0, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++;
      $display("FAIL fu_addr_ack got %b want 0", a); end
    write_byte(8'h11, a);
    n_cmp++; if (a !== 1'b1) begin n_bad++;
      $display("FAIL fu_data_nack got %b want 1", a); end
    i2c_stop();
    full_rx = 1'b0;
    wclk(5);
    n_cmp++; if (wr_cnt - w0 !== 0) begin n_bad++;
      $display("FAIL fu_writes got %0d want 0", wr_cnt - w0); end
  endtask

  task automatic test_restart();
    int w0, r0;
    logic a;
    logic [7:0] d;
    logic [3:0] ix;
    w0 = wr_cnt; r0 = rd_cnt;
    ix = w0[3:0];
    tx_mem[r0[2:0]] = 8'h5A;
    tx_lim = r0 + 1;
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h22, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++;
      $display("FAIL rs_d_ack got %b want 0", a); end
    i2c_start();
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL rs_busy got %b want 1", busy); end
    write_byte(8'hA1, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++;
      $display("FAIL rs_addr_ack got %b want 0", a); end
    read_byte(1'b1, d);
    n_cmp++; if (d !== 8'h5A) begin n_bad++;
      $display("FAIL rs_rd got %h want 5a", d); end
    i2c_stop();
    wclk(5);
    n_cmp++; if (wr_cnt - w0 !== 1 || wr_log[ix] !== 8'h22) begin
      n_bad++;
      $display("FAIL rs_write got n %0d d %h want 1 22",
               wr_cnt - w0, wr_log[ix]); end
    n_cmp++; if (rd_cnt - r0 !== 1) begin n_bad++;
      $display("FAIL rs_reads got %0d want 1", rd_cnt - r0); end
  endtask

  task automatic test_reset_mid();
    logic s;
    logic [7:0] ad;
    ad = 8'hA0;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(ad[i], s);
    m_drv = 1'b0;
    wclk(2 * Q);
    n_cmp++; if (sda !== 1'b0) begin n_bad++;
      $display("FAIL mid_ack_drv got %b want 0", sda); end
    reset = 1'b0;
    #1;
    n_cmp++; if (sda !== 1'b1) begin n_bad++;
      $display("FAIL mid_sda got %b want 1", sda); end
    n_cmp++; if (busy !== 1'b0 || read !== 1'b0
                 || write !== 1'b0) begin n_bad++;
      $display("FAIL mid_ctl got b%b r%b w%b want 000",
               busy, read, write); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++;
      $display("FAIL mid_data got %h want 00", data_out); end
    scl = 1'b1;
    wclk(5);
    reset = 1'b1;
    wclk(5);
  endtask

  task automatic test_back_to_back();
    int w0;
    logic a;
    logic [3:0] ix;
    w0 = wr_cnt;
    ix = w0[3:0];
    i2c_start();
    write_byte(8'hA0, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++;
      $display("FAIL bb_addr_ack got %b want 0", a); end
    write_byte(8'h7E, a);
    i2c_stop();
    wclk(5);
    n_cmp++; if (wr_cnt - w0 !== 1 || wr_log[ix] !== 8'h7E) begin
      n_bad++;
      $display("FAIL bb_write got n %0d d %h want 1 7e",
               wr_cnt - w0, wr_log[ix]); end
    n_cmp++; if (both_cnt !== 0) begin n_bad++;
      $display("FAIL rd_wr_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_empty();
    test_full();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
